// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data RAM arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker with a registered last-grant pointer.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant,
    output logic       o_last_grant
);

    logic r_last_grant;

    assign o_last_grant = r_last_grant;

    // Pick the single requester, or on a tie the one not granted last.
    always_comb begin
        // NOTE: default first so every path assigns o_grant and no latch is inferred.
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (r_last_grant == PORT_IF) ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    // Remember who won whenever the grant is actually taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= PORT_IF;
        end else if (i_advance && (o_grant != 2'b00)) begin
            // NOTE: non-blocking for all clocked state so every flop samples pre-edge values.
            r_last_grant <= o_grant[PORT_D] ? PORT_D : PORT_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered-read RAM between instruction fetch and load/store.
// Each access is IDLE/RESP -> ACCESS -> RESP, so a new request is accepted
// in the same cycle the previous response is strobed.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_out
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [1:0]        w_grant;
    logic              w_owner;
    logic              w_can_accept;
    logic              w_accept;

    assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_RESP);
    assign w_accept     = w_can_accept && (w_grant != 2'b00);

    // The arbiter pointer moves on every acceptance, so it always names the
    // owner of the transaction currently in ACCESS/RESP.
    rr_arbiter2 u_rr (
        .clk          (clk),
        .rst          (rst),
        .i_req        ({d_req_valid, if_req_valid}),
        .i_advance    (w_accept),
        .o_grant      (w_grant),
        .o_last_grant (w_owner)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state: accept from IDLE/RESP, ACCESS always hands over to RESP.
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_next = w_accept ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: w_next = ST_RESP;
            ST_RESP:   w_next = w_accept ? ST_ACCESS : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Capture the winner's request; fetches are forced to reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (w_accept) begin
            if (w_grant[PORT_D]) begin
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
                r_we    <= d_we;
            end else begin
                r_addr  <= if_addr;
                r_we    <= 1'b0;
            end
        end
    end

    assign if_req_ready = w_can_accept && w_grant[PORT_IF] && !rst;
    assign d_req_ready  = w_can_accept && w_grant[PORT_D]  && !rst;

    assign if_rsp_valid = (r_state == ST_RESP) && (w_owner == PORT_IF) && !rst;
    assign d_rsp_valid  = (r_state == ST_RESP) && (w_owner == PORT_D)  && !rst;

    assign ram_addr = r_addr;
    assign ram_in   = r_wdata;
    assign ram_wen  = (r_state == ST_ACCESS) && r_we && !rst;

    assign if_rdata = ram_out;
    assign d_rdata  = ram_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed registered-read RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [15:0] if_addr;
    logic [31:0] if_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid;
    logic [15:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic [15:0] ram_addr;
    logic [31:0] ram_in, ram_out;
    logic        ram_wen;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rdata     (if_rdata),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_addr       (d_addr),
        .d_we         (d_we),
        .d_wdata      (d_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rdata      (d_rdata),
        .ram_addr     (ram_addr),
        .ram_in       (ram_in),
        .ram_wen      (ram_wen),
        .ram_out      (ram_out)
    );

    // Little-endian RAM: posedge write, registered read, 16-bit address wrap.
    always @(posedge clk) begin
        if (ram_wen) begin
            for (int k = 0; k < 4; k++) mem[16'(ram_addr + 16'(k))] <= ram_in[8*k +: 8];
        end
        ram_out <= {mem[16'(ram_addr + 16'd3)], mem[16'(ram_addr + 16'd2)],
                    mem[16'(ram_addr + 16'd1)], mem[ram_addr]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated transaction starting from IDLE; returns in its RESP cycle.
    task automatic txn(input string tag, input bit is_d, input logic [15:0] addr,
                       input bit we, input logic [31:0] wdata, input logic [31:0] exp_rd);
        @(negedge clk);
        if (is_d) begin
            d_req_valid = 1'b1; d_addr = addr; d_we = we; d_wdata = wdata;
        end else begin
            if_req_valid = 1'b1; if_addr = addr;
        end
        #1;
        chk({tag, "_ready"}, is_d ? d_req_ready : if_req_ready, 32'd1);
        chk({tag, "_other_ready"}, is_d ? if_req_ready : d_req_ready, 32'd0);
        @(negedge clk);
        d_req_valid = 1'b0; if_req_valid = 1'b0;
        #1;
        chk({tag, "_acc_wen"}, ram_wen, 32'(we));
        chk({tag, "_acc_addr"}, ram_addr, 32'(addr));
        if (we) chk({tag, "_acc_in"}, ram_in, wdata);
        chk({tag, "_acc_rsp"}, {if_rsp_valid, d_rsp_valid}, 32'd0);
        @(negedge clk); #1;
        chk({tag, "_rsp_d"}, d_rsp_valid, 32'(is_d));
        chk({tag, "_rsp_if"}, if_rsp_valid, 32'(!is_d));
        chk({tag, "_rsp_wen"}, ram_wen, 32'd0);
        if (!we) chk({tag, "_rdata"}, is_d ? d_rdata : if_rdata, exp_rd);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[4] = 8'h01; mem[5] = 8'h02; mem[6] = 8'h03; mem[7] = 8'h04;
        mem[16'h20] = 8'hA0; mem[16'h21] = 8'hA1; mem[16'h22] = 8'hA2; mem[16'h23] = 8'hA3;

        // Reset state, with requests already asserted.
        rst = 1'b1;
        if_req_valid = 1'b1; if_addr = 16'h0004;
        d_req_valid  = 1'b1; d_addr  = 16'h0010; d_we = 1'b0; d_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_if_ready", if_req_ready, 0);
        chk("rst_d_ready",  d_req_ready, 0);
        chk("rst_rsp", {if_rsp_valid, d_rsp_valid}, 0);
        chk("rst_wen", ram_wen, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_in", ram_in, 0);
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk); rst = 1'b0;

        // Data write then read-back.
        txn("dwr", 1'b1, 16'h0010, 1'b1, 32'hDEADBEEF, 32'h0);
        txn("drd", 1'b1, 16'h0010, 1'b0, 32'h0, 32'hDEADBEEF);
        // Fetch of preloaded bytes.
        txn("ifrd", 1'b0, 16'h0004, 1'b0, 32'h0, 32'h04030201);
        @(negedge clk); #1;
        chk("idle_rsp", {if_rsp_valid, d_rsp_valid}, 0);

        // Contention from reset: D, IF, D with one acceptance per two cycles.
        rst = 1'b1;
        if_req_valid = 1'b1; if_addr = 16'h0004;
        d_req_valid  = 1'b1; d_addr  = 16'h0020; d_we = 1'b0;
        @(negedge clk); rst = 1'b0; #1;
        chk("ct0_d_ready", d_req_ready, 1);
        chk("ct0_if_ready", if_req_ready, 0);
        @(negedge clk); #1;
        chk("ct1_addr", ram_addr, 32'h20);
        chk("ct1_ready", {if_req_ready, d_req_ready}, 0);
        chk("ct1_rsp", {if_rsp_valid, d_rsp_valid}, 0);
        @(negedge clk); #1;
        chk("ct2_rsp", {if_rsp_valid, d_rsp_valid}, 2'b01);
        chk("ct2_rdata", d_rdata, 32'hA3A2A1A0);
        chk("ct2_ready", {if_req_ready, d_req_ready}, 2'b10);
        @(negedge clk); #1;
        chk("ct3_addr", ram_addr, 32'h4);
        chk("ct3_rsp", {if_rsp_valid, d_rsp_valid}, 0);
        @(negedge clk); #1;
        chk("ct4_rsp", {if_rsp_valid, d_rsp_valid}, 2'b10);
        chk("ct4_rdata", if_rdata, 32'h04030201);
        chk("ct4_ready", {if_req_ready, d_req_ready}, 2'b01);
        @(negedge clk); #1;
        chk("ct5_addr", ram_addr, 32'h20);
        chk("ct5_rsp", {if_rsp_valid, d_rsp_valid}, 0);
        @(negedge clk); #1;
        chk("ct6_rsp", {if_rsp_valid, d_rsp_valid}, 2'b01);
        chk("ct6_ready", {if_req_ready, d_req_ready}, 2'b10);
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk); #1;
        chk("ct7_rsp", {if_rsp_valid, d_rsp_valid}, 0);
        chk("ct7_addr", ram_addr, 32'h20);

        // Withdrawn fetch while data owns the RAM.
        @(negedge clk);
        d_req_valid = 1'b1; d_addr = 16'h0010; d_we = 1'b0; #1;
        chk("wd_d_ready", d_req_ready, 1);
        @(negedge clk);
        d_req_valid = 1'b0; if_req_valid = 1'b1; if_addr = 16'h0004; #1;
        chk("wd_acc_if_ready", if_req_ready, 0);
        @(negedge clk);
        if_req_valid = 1'b0; #1;
        chk("wd_rsp", {if_rsp_valid, d_rsp_valid}, 2'b01);
        chk("wd_rdata", d_rdata, 32'hDEADBEEF);
        @(negedge clk); #1;
        chk("wd_idle_rsp", {if_rsp_valid, d_rsp_valid}, 0);
        chk("wd_idle_addr", ram_addr, 32'h10);
        @(negedge clk); #1;
        chk("wd_idle2_rsp", {if_rsp_valid, d_rsp_valid}, 0);

        // Reset in the middle of a write's ACCESS cycle.
        @(negedge clk);
        d_req_valid = 1'b1; d_addr = 16'h0040; d_we = 1'b1; d_wdata = 32'hCAFEF00D;
        @(negedge clk);
        d_req_valid = 1'b0; #1;
        chk("rw_acc_wen", ram_wen, 1);
        rst = 1'b1; #1;
        chk("rw_wen_drop", ram_wen, 0);
        chk("rw_rsp", {if_rsp_valid, d_rsp_valid}, 0);
        @(negedge clk); #1;
        chk("rw_rsp2", {if_rsp_valid, d_rsp_valid}, 0);
        rst = 1'b0;
        if_req_valid = 1'b1; if_addr = 16'h0004; #1;
        chk("rw_if_ready", if_req_ready, 1);
        if_req_valid = 1'b0;
        d_req_valid = 1'b1; d_we = 1'b0; #1;
        chk("rw_d_ready", d_req_ready, 1);
        d_req_valid = 1'b0; #1;
        chk("rw_rsp3", {if_rsp_valid, d_rsp_valid}, 0);
        txn("rw_fresh", 1'b0, 16'h0004, 1'b0, 32'h0, 32'h04030201);

        // Top-of-memory access wraps in the RAM, address passes through unchanged.
        txn("wrap_wr", 1'b1, 16'hFFFE, 1'b1, 32'h11223344, 32'h0);
        txn("wrap_rd", 1'b1, 16'hFFFE, 1'b0, 32'h0, 32'h11223344);
        @(negedge clk); #1;
        chk("end_rsp", {if_rsp_valid, d_rsp_valid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
